synch_fifo_thr: RTL
===================

# synch_fifo_thr

Parametrised synchronous FIFO, successor to the single-flag buffer used between the SDRAM controller command/data paths and client logic. All DEPTH entries are usable, and it adds an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. Read data is registered by default; a compile-time first-word-fall-through mode serves streaming consumers such as the SDRAM write-data path.

## Interface
- DEPTH, 8: number of entries; power of two, ≥ 2.
- DATA_WIDTH, 8: word width in bits.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH; range 1..DEPTH.
- AE_THRESH, 1: almost_empty asserts when count ≤ AE_THRESH; range 0..DEPTH-1.
- AW (local), log2(DEPTH): address width. Pointers are AW+1 bits.

- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request or pop.
- data_out  out  DATA_WIDTH  read data.
- valid  out  1  data_out qualifier.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  AW+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; a write was attempted while full.
- underflow  out  1  sticky; a read was attempted while empty.

## Operation
- Storage is DEPTH × DATA_WIDTH memory. The memory is not reset.
- w_ptr and r_ptr are AW+1 bits. The low AW bits index memory. The MSB is the wrap bit.
- empty = (w_ptr == r_ptr).
- full = (low bits equal) and (MSBs differ).
- count = w_ptr − r_ptr, computed modulo 2^(AW+1).
- Accepted write (w_en & !full): mem[w_ptr] ← data_in, then w_ptr + 1.
- Accepted read (r_en & !empty): r_ptr + 1.
- Acceptance is decided on the flags at the current edge. A write while full is dropped even if a read is accepted in the same cycle. A read while empty is dropped even if a write occurs in the same cycle.
- Simultaneous accepted read and write: both pointers advance and count is unchanged. This holds at any occupancy between 1 and DEPTH-1.
- overflow sets on w_en & full. underflow sets on r_en & empty. Both hold until rst.
- almost_full and almost_empty are decoded combinationally from the pointer registers.
- Non-FWFT mode:
  - An accepted read registers mem[r_ptr] into data_out, and valid=1 on the next cycle.
  - Any cycle without an accepted read gives valid=0.
  - data_out holds its last value; it is not cleared.

## Timing
- Reset values: w_ptr=r_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (given AF_THRESH ≥ 1), overflow=underflow=0, valid=0, data_out=0.
- rst asserted mid-operation discards all contents on that edge. In FWFT mode, stale memory is never exposed as valid.
- Flags and count reflect each accepted operation in the cycle after the edge.
- Write to read: data written at edge N is readable with r_en at edge N+1.
- Non-FWFT read latency: r_en at edge N gives data_out and valid=1 after edge N.
- Full throughput: one write and one read per cycle indefinitely.
- Pointers wrap naturally at 2^(AW+1). No special case is needed.

## Configuration
- SYNCH_FIFO_FWFT_EN defined:
  - data_out = mem[r_ptr] combinationally, and valid = !empty.
  - r_en acts as a pop of the presented word.
  - The first write appears on data_out one cycle after the write edge.
  - data_out has no reset value. It is don't-care while valid=0.
- SYNCH_FIFO_FWFT_EN undefined: registered-read behaviour as described under Operation.

## Test plan
- Reset, then write 0x11..0x18 with DEPTH=8 → full=1 after 8th write, count=8, almost_full=1 from count 6; 9th write dropped and overflow=1.
- Read all 8 from full → data 0x11..0x18 in order, valid one cycle after each r_en (non-FWFT); empty=1, almost_empty=1 at count ≤ 1; extra read sets underflow=1.
- Simultaneous w_en/r_en at count=4 for 20 cycles → count stays 4, data order preserved across pointer wrap.
- r_en & w_en while empty → write accepted, read ignored, underflow=1, count=1; w_en & r_en while full → read accepted, write dropped, overflow=1, count=7.
- Assert rst at count=5 → next cycle count=0, empty=1, valid=0, overflow=underflow=0.
- FWFT build: write 0xA5 to empty FIFO → next cycle valid=1, data_out=0xA5 without r_en; r_en pops → valid=0.

Source files
------------

// File: rtl/synch_fifo_thr.sv
// synch_fifo_thr: parametrised synchronous FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds and sticky error flags.
//
// Optional feature macro: SYNCH_FIFO_FWFT_EN
//   defined   -> first-word-fall-through: data_out shows the head word
//                combinationally, valid = !empty, r_en pops.
//   undefined -> registered read: an accepted read loads data_out and
//                raises valid for one cycle.
//
// Ports:
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   w_en, data_in write request and data
//   r_en          read request / pop
//   data_out      read data, qualified by valid
//   full, empty   occupancy == DEPTH / == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy 0..DEPTH
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
module synch_fifo_thr #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AF_THRESH  = DEPTH - 2,
  parameter int unsigned AE_THRESH  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_en,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    r_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  localparam logic [AW:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [AW:0] AE_LVL = PW'(AE_THRESH);
  localparam logic [AW:0] PTR_ONE = PW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [AW:0] w_ptr_q, w_ptr_d;
  logic [AW:0] r_ptr_q, r_ptr_d;
  logic        ovf_q, ovf_d;
  logic        unf_q, unf_d;
  logic        wr_acc, rd_acc;

  // Status decoded from the pointer registers; the extra MSB tells full from empty.
  assign empty        = (w_ptr_q == r_ptr_q);
  assign full         = (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]) &&
                        (w_ptr_q[AW] != r_ptr_q[AW]);
  assign count        = w_ptr_q - r_ptr_q;
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // Acceptance uses the flags as they stand before this edge.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // Next-state for pointers and sticky error flags.
  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (wr_acc) w_ptr_d = w_ptr_q + PTR_ONE;
    if (rd_acc) r_ptr_d = r_ptr_q + PTR_ONE;
    if (w_en && full)  ovf_d = 1'b1;
    if (r_en && empty) unf_d = 1'b1;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage array, intentionally not reset; a write during rst lands
  // in a slot that the reset pointers already treat as free.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[w_ptr_q[AW-1:0]] <= data_in;
  end

`ifdef SYNCH_FIFO_FWFT_EN
  // Head word is always presented; pointer reset hides stale memory.
  assign data_out = mem_q[r_ptr_q[AW-1:0]];
  assign valid    = ~empty;
`else
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_q, valid_d;

  // Registered read: load on accepted read, otherwise hold data and drop valid.
  always_comb begin
    data_out_d = data_out_q;
    valid_d    = rd_acc;
    if (rd_acc) data_out_d = mem_q[r_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  assign data_out = data_out_q;
  assign valid    = valid_q;
`endif

endmodule
